ssrv_mem_responder: RTL and testbench
=====================================

// Module: ssrv_mem_responder
// PURPOSE
//  Fuzz-driven SCR1 memory slave feeding imem_/dmem_ req_ack/rdata/resp of ssrv_top (one instance per port).
//  Accepts core requests into an in-order queue, holds each for a fixed latency, then returns a
//  response whose read data and error flag are pulled from a fuzzer stream. Replaces real memory in fuzz builds.
// PARAMETERS
//  DEPTH      4   max outstanding requests (power of 2, >=2)
//  LAT        2   cycles from accept to earliest response (>=1, <=15)
//  DWIDTH     32  data width (`SCR1_IMEM_DWIDTH / `SCR1_DMEM_DWIDTH)
// PORTS
//  clk           in   1       core clock
//  rst_n         in   1       async active-low reset
//  mem_req       in   1       core request valid
//  mem_cmd       in   type_scr1_mem_cmd_e  RD/WR (tie RD for imem)
//  mem_addr      in   32      request address (unused except for trace)
//  mem_wdata     in   DWIDTH  write data (ignored; discarded)
//  mem_req_ack   out  1       request accepted this cycle
//  mem_rdata     out  DWIDTH  read data, valid when mem_resp==RDY_OK
//  mem_resp      out  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER
//  fz_valid      in   1       fuzz word available
//  fz_data       in   DWIDTH  fuzz read-data word
//  fz_err        in   1       fuzz word marks bus error
//  fz_ready      out  1       fuzz word consumed this cycle
//  resp_cnt      out  16      responses issued, saturating at 16'hFFFF
//  err_cnt       out  8       RDY_ER responses issued, saturating at 8'hFF
// BEHAVIOUR
//  - Reset (rst_n=0, async): queue empty, mem_req_ack=0, mem_rdata=0, mem_resp=NOTRDY, fz_ready=0, counters 0.
//  - mem_req_ack = mem_req && (count < DEPTH); combinational, no full-queue bypass. Accept = req && ack.
//  - On accept push {cmd, timer=LAT}. Every entry timer decrements each cycle, saturating at 0.
//  - Head ready when timer==0. Response (combinational from head + fz_*), at most one per cycle, in order:
//      WR head: mem_resp=RDY_OK, rdata=0, pop; fz stream untouched.
//      RD head & fz_valid: rdata=fz_data, resp=fz_err?RDY_ER:RDY_OK, fz_ready=1, pop. rdata=0 on RDY_ER.
//      RD head & !fz_valid: resp=NOTRDY, no pop (stall until fuzz word arrives).
//      Queue empty or head timer>0: resp=NOTRDY, rdata=0, fz_ready=0.
//  - Minimum latency: accept in cycle N -> response earliest cycle N+LAT.
//  - Simultaneous push and pop: both take effect; count unchanged. Push when full never happens (ack=0).
//  - Pointers wrap mod DEPTH; count is $clog2(DEPTH)+1 bits.
//  - resp_cnt/err_cnt increment on every pop (err_cnt only on RDY_ER); hold at max.
//  - Async reset mid-transaction drops all queued requests; no response is owed after reset release.
// STRUCTURE
//  - Shared: type_scr1_mem_cmd_e / type_scr1_mem_resp_e and width macros from scr1_memif.svh; add
//    SSRV_RESP_LAT_W (4) to a ssrv_pkg package.
//  - Sub-module ssrv_resp_fifo: DEPTH-entry in-order queue holding {cmd, timer}, with per-entry timer
//    decrement and push/pop/full/empty/count. Top handles ack, fz handshake, response mux, counters.
// TESTING
//  1 Reset: assert rst_n=0 mid-burst -> next cycle resp=NOTRDY, ack=0, resp_cnt=0; queue empty after release.
//  2 Single RD, LAT=2, fz_valid=1 data=32'hDEADBEEF: accept cycle 0 -> cycle 2 resp=RDY_OK, rdata=DEADBEEF, fz_ready=1.
//  3 Fill: DEPTH=4, mem_req held high, fz_valid=0 -> 4 acks then ack=0; raise fz_valid -> 4 in-order responses, ack resumes.
//  4 Error: RD with fz_err=1 -> resp=RDY_ER, rdata=0, err_cnt 0->1, resp_cnt 0->1.
//  5 Mixed WR,RD,WR back-to-back, fz_valid=0 -> WR RDY_OK at cycle 2; RD stalls NOTRDY; second WR blocked behind it.
//  6 Saturation: force 65540 responses -> resp_cnt stays 16'hFFFF; push+pop same cycle keeps count constant.

Source files
------------

// File: rtl/ssrv_pkg.sv
// Shared types for the fuzz-driven SCR1 memory responder.
// Pure declarations: no logic, no latency.
// Not applicable (no handshake lives here).
package ssrv_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    localparam int SSRV_DWIDTH     = 32;
    localparam int SSRV_RESP_LAT_W = 4;

    // One outstanding request: what it was and how long before it may answer.
    typedef struct packed {
        type_scr1_mem_cmd_e          cmd;
        logic [SSRV_RESP_LAT_W-1:0]  timer;
    } ssrv_resp_entry_t;

endpackage

// File: rtl/ssrv_resp_fifo.sv
// In-order queue of outstanding requests, each with a countdown to its earliest response.
// Push visible at head next cycle; head ready LAT cycles after its push cycle.
// No internal backpressure: caller must not push when full or pop when head not ready.
module ssrv_resp_fifo
    import ssrv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LAT   = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  type_scr1_mem_cmd_e  i_push_cmd,
    input  logic                i_pop,
    output type_scr1_mem_cmd_e  o_head_cmd,
    output logic                o_head_rdy,
    output logic                o_full,
    output logic                o_empty,
    output logic [CNT_W-1:0]    o_count
);

    // The accept cycle itself counts as the first tick, so a new entry is
    // loaded with LAT-1 and reaches zero exactly LAT cycles after accept.
    localparam logic [SSRV_RESP_LAT_W-1:0] TIMER_LOAD = SSRV_RESP_LAT_W'(LAT - 1);

    ssrv_resp_entry_t    r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    ssrv_resp_entry_t    w_head;

    // Storage, timers and pointers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_mem[i].timer != '0) begin
                    r_mem[i].timer <= r_mem[i].timer - SSRV_RESP_LAT_W'(1);
                end
            end
            if (i_push) begin
                r_mem[r_wr_ptr] <= '{cmd: i_push_cmd, timer: TIMER_LOAD};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign o_head_cmd = w_head.cmd;
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_head_rdy = !o_empty && (w_head.timer == '0);
    assign o_count    = r_count;

endmodule

// File: rtl/ssrv_mem_responder.sv
// Fuzz-driven SCR1 memory slave: queues requests, answers in order with fuzzer-supplied data/error.
// Response no earlier than LAT cycles after accept; reads additionally wait for a fuzz word.
// req_ack drops while DEPTH requests are outstanding; a stalled read head blocks everything behind it.
module ssrv_mem_responder
    import ssrv_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int LAT    = 2,
    parameter int DWIDTH = SSRV_DWIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_mem_req,
    input  type_scr1_mem_cmd_e   i_mem_cmd,
    input  logic [31:0]          i_mem_addr,
    input  logic [DWIDTH-1:0]    i_mem_wdata,
    output logic                 o_mem_req_ack,
    output logic [DWIDTH-1:0]    o_mem_rdata,
    output type_scr1_mem_resp_e  o_mem_resp,
    input  logic                 i_fz_valid,
    input  logic [DWIDTH-1:0]    i_fz_data,
    input  logic                 i_fz_err,
    output logic                 o_fz_ready,
    output logic [15:0]          o_resp_cnt,
    output logic [7:0]           o_err_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    type_scr1_mem_cmd_e  w_head_cmd;
    logic                w_head_rdy;
    logic                w_full;
    logic                w_empty;
    logic [CNT_W-1:0]    w_count;
    logic                w_push;
    logic                w_pop;
    logic [15:0]         r_resp_cnt;
    logic [7:0]          r_err_cnt;
    logic                w_unused;

    // Address and write data only exist for tracing; writes are discarded.
    assign w_unused = ^{i_mem_addr, i_mem_wdata, w_empty, w_count};

    // No bypass when full: a pop in the same cycle does not free a slot for ack.
    assign o_mem_req_ack = i_mem_req && !w_full;
    assign w_push        = o_mem_req_ack;

    ssrv_resp_fifo #(
        .DEPTH (DEPTH),
        .LAT   (LAT)
    ) u_resp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_cmd (i_mem_cmd),
        .i_pop      (w_pop),
        .o_head_cmd (w_head_cmd),
        .o_head_rdy (w_head_rdy),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    // Response mux: writes answer on their own, reads need a fuzz word; rdata only carries data on RDY_OK reads.
    always_comb begin
        o_mem_resp  = SCR1_MEM_RESP_NOTRDY;
        o_mem_rdata = '0;
        o_fz_ready  = 1'b0;
        w_pop       = 1'b0;
        if (w_head_rdy) begin
            if (w_head_cmd == SCR1_MEM_CMD_WR) begin
                o_mem_resp = SCR1_MEM_RESP_RDY_OK;
                w_pop      = 1'b1;
            end else if (i_fz_valid) begin
                o_fz_ready = 1'b1;
                w_pop      = 1'b1;
                if (i_fz_err) begin
                    o_mem_resp = SCR1_MEM_RESP_RDY_ER;
                end else begin
                    o_mem_resp  = SCR1_MEM_RESP_RDY_OK;
                    o_mem_rdata = i_fz_data;
                end
            end
        end
    end

    // Saturating response / error counters, stepped once per issued response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (w_pop) begin
            if (r_resp_cnt != 16'hFFFF) begin
                r_resp_cnt <= r_resp_cnt + 16'd1;
            end
            if ((o_mem_resp == SCR1_MEM_RESP_RDY_ER) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign o_resp_cnt = r_resp_cnt;
    assign o_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_ssrv_mem_responder.sv
// Randomized bench for ssrv_mem_responder against a timestamp-based queue model.
// Inputs driven at negedge, outputs compared 1 time unit later.
// Model tracks accept cycle per request; response due once LAT cycles have elapsed.
module tb_ssrv_mem_responder;
    import ssrv_pkg::*;

    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int DW    = 32;

    logic                 clk;
    logic                 rst_n;
    logic                 i_mem_req;
    type_scr1_mem_cmd_e   i_mem_cmd;
    logic [31:0]          i_mem_addr;
    logic [DW-1:0]        i_mem_wdata;
    logic                 o_mem_req_ack;
    logic [DW-1:0]        o_mem_rdata;
    type_scr1_mem_resp_e  o_mem_resp;
    logic                 i_fz_valid;
    logic [DW-1:0]        i_fz_data;
    logic                 i_fz_err;
    logic                 o_fz_ready;
    logic [15:0]          o_resp_cnt;
    logic [7:0]           o_err_cnt;

    ssrv_mem_responder #(
        .DEPTH  (DEPTH),
        .LAT    (LAT),
        .DWIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_mem_req     (i_mem_req),
        .i_mem_cmd     (i_mem_cmd),
        .i_mem_addr    (i_mem_addr),
        .i_mem_wdata   (i_mem_wdata),
        .o_mem_req_ack (o_mem_req_ack),
        .o_mem_rdata   (o_mem_rdata),
        .o_mem_resp    (o_mem_resp),
        .i_fz_valid    (i_fz_valid),
        .i_fz_data     (i_fz_data),
        .i_fz_err      (i_fz_err),
        .o_fz_ready    (o_fz_ready),
        .o_resp_cnt    (o_resp_cnt),
        .o_err_cnt     (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: outstanding requests as (is_write, accept cycle), plus plain counts.
    logic q_wr  [$];
    int   q_acc [$];
    int   m_resp = 0;
    int   m_err  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive, compare against model, advance model, wait for next negedge.
    task automatic step(input logic req, input logic wr, input logic fzv,
                        input logic [31:0] fzd, input logic fze);
        logic        e_ack;
        logic        e_pop;
        logic        e_fzr;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        i_mem_req   = req;
        i_mem_cmd   = wr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
        i_mem_addr  = $urandom;
        i_mem_wdata = $urandom;
        i_fz_valid  = fzv;
        i_fz_data   = fzd;
        i_fz_err    = fze;
        #1;
        e_ack   = req && (q_wr.size() < DEPTH);
        e_pop   = 1'b0;
        e_fzr   = 1'b0;
        e_resp  = 2'd0;
        e_rdata = '0;
        if (q_wr.size() > 0 && cyc >= q_acc[0] + LAT) begin
            if (q_wr[0]) begin
                e_resp = 2'd1;
                e_pop  = 1'b1;
            end else if (fzv) begin
                e_fzr   = 1'b1;
                e_pop   = 1'b1;
                e_resp  = fze ? 2'd2 : 2'd1;
                e_rdata = fze ? 32'd0 : fzd;
            end
        end
        chk("ack",      32'(o_mem_req_ack), 32'(e_ack));
        chk("resp",     32'(o_mem_resp),    32'(e_resp));
        chk("rdata",    o_mem_rdata,        e_rdata);
        chk("fz_ready", 32'(o_fz_ready),    32'(e_fzr));
        chk("resp_cnt", 32'(o_resp_cnt),    (m_resp > 65535) ? 32'd65535 : 32'(m_resp));
        chk("err_cnt",  32'(o_err_cnt),     (m_err > 255) ? 32'd255 : 32'(m_err));
        if (rst_n) begin
            if (e_pop) begin
                void'(q_wr.pop_front());
                void'(q_acc.pop_front());
                m_resp++;
                if (e_resp == 2'd2) m_err++;
            end
            if (e_ack) begin
                q_wr.push_back(wr);
                q_acc.push_back(cyc);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    // Asynchronous reset landing between clock edges while traffic is in flight.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        q_wr.delete();
        q_acc.delete();
        m_resp = 0;
        m_err  = 0;
        @(negedge clk);
        cyc++;
        repeat (2) step(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
        rst_n = 1'b1;
        // Nothing may be answered after release: fuzz words are offered but must not be consumed.
        repeat (LAT + 2) step(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        i_mem_req   = 1'b0;
        i_mem_cmd   = SCR1_MEM_CMD_RD;
        i_mem_addr  = '0;
        i_mem_wdata = '0;
        i_fz_valid  = 1'b0;
        i_fz_data   = '0;
        i_fz_err    = 1'b0;
        repeat (3) @(negedge clk);
        // Reset state observed with reset still asserted.
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        rst_n = 1'b1;

        // Single read answered with DEADBEEF two cycles after accept.
        step(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);

        // Fill with no fuzz words, then drain in order while requests keep coming.
        repeat (7) step(1'b1, 1'b0, 1'b0, $urandom, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b1, $urandom, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b1, $urandom, 1'b0);

        // Bus error read.
        step(1'b1, 1'b0, 1'b0, $urandom, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, $urandom, 1'b1);

        // WR, RD, WR back to back; the read stalls and holds the second write.
        step(1'b1, 1'b1, 1'b0, $urandom, 1'b0);
        step(1'b1, 1'b0, 1'b0, $urandom, 1'b0);
        step(1'b1, 1'b1, 1'b0, $urandom, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0, $urandom, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b1, $urandom, 1'b0);

        // Reset in the middle of a burst.
        repeat (3) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, $urandom, 1'b0);
        mid_reset();

        // Random traffic with occasional mid-burst resets.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 4) == 0));
            if (i % 700 == 699) mid_reset();
        end

        // Saturation: back-to-back traffic until both counters pin at their maxima.
        for (int i = 0; i < 65600; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b1, $urandom, 1'($urandom_range(0, 3) == 0));
        end
        chk("resp_cnt_sat", 32'(o_resp_cnt), 32'h0000FFFF);
        chk("err_cnt_sat",  32'(o_err_cnt),  32'h000000FF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
